// File: rtl/telemetry_frame_builder.sv
// Builds one telemetry frame per accepted frame strobe edge into the frame RAM.
// Optional feature macro FRAME_CRC_EN appends a CRC-16-CCITT word after the serial number.
module telemetry_frame_builder #(
  parameter logic [15:0] SYNC_WORD = 16'hFF7F,
  parameter int          I2C_WORDS = 10,
  parameter int          GPS_WORDS = 14,
  parameter int          EXT_WORDS = 64,
  parameter int          PAD_WORDS = 4,
  parameter int          ADDR_W    = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     frame,
  input  logic [3:0]               frame_cnt,
  input  logic [16*I2C_WORDS-1:0]  i2c_data,
  input  logic [16*GPS_WORDS-1:0]  gps_data,
  output logic [ADDR_W-1:0]        ext_rd_addr,
  input  logic [15:0]              ext_data,
  input  logic [31:0]              serial_number,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [15:0]              wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
);

  typedef enum logic [3:0] {
    IDLE, SYNC, COUNT, I2C, GPS, EXT_ADDR, EXT_WAIT, PAD, SER_HI, SER_LO,
`ifdef FRAME_CRC_EN
    CRC,
`endif
    DONE
  } state_t;

  // Section order with empty sections folded out at elaboration time.
  localparam state_t AFTER_EXT   = state_t'((PAD_WORDS > 0) ? PAD : SER_HI);
  localparam state_t AFTER_GPS   = state_t'((EXT_WORDS > 0) ? EXT_ADDR : AFTER_EXT);
  localparam state_t AFTER_I2C   = state_t'((GPS_WORDS > 0) ? GPS : AFTER_GPS);
  localparam state_t AFTER_COUNT = state_t'((I2C_WORDS > 0) ? I2C : AFTER_I2C);

  localparam logic [15:0]       I2C_LAST = 16'(I2C_WORDS - 1);
  localparam logic [15:0]       GPS_LAST = 16'(GPS_WORDS - 1);
  localparam logic [15:0]       EXT_LAST = 16'(EXT_WORDS - 1);
  localparam logic [15:0]       PAD_LAST = 16'(PAD_WORDS - 1);
  localparam logic [ADDR_W-1:0] EXT_STEP = ADDR_W'(EXT_WORDS);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t                   state_r, state_nx_s;
  logic [15:0]              idx_r, idx_nx_s;
  logic                     frame_d_r;
  logic                     edge_s;
  logic [15:0]              frame_counter_r;
  logic [16*I2C_WORDS-1:0]  i2c_sh_r;
  logic [16*GPS_WORDS-1:0]  gps_sh_r;
  logic [ADDR_W-1:0]        ext_rd_addr_r;
  logic [ADDR_W-1:0]        ext_base_s;
  logic                     wr_en_r;
  logic [ADDR_W-1:0]        wr_addr_r;
  logic [15:0]              wr_data_r;
  logic [15:0]              wr_data_nx_s;
  logic                     busy_r;
  logic                     done_r;
  logic                     overrun_r;
  logic                     unused_s;

`ifdef FRAME_CRC_EN
  logic [15:0] crc_r;

  // Word-wide CRC-16-CCITT step, MSB first, no reflection.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc_in, input logic [15:0] data);
    logic [15:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 16; i++) begin
      if (c[15]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else       c = {c[14:0], 1'b0};
    end
    return c;
  endfunction
`endif

  assign edge_s     = frame & ~frame_d_r;
  assign ext_base_s = EXT_STEP * ADDR_W'(frame_cnt[3:2]);
  assign unused_s   = ^frame_cnt[1:0];

  // Next-state sequencing and per-section word index.
  always_comb begin
    state_nx_s = state_r;
    idx_nx_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (edge_s) state_nx_s = SYNC;
        else        state_nx_s = IDLE;
      end
      SYNC:  state_nx_s = COUNT;
      COUNT: begin
        state_nx_s = AFTER_COUNT;
        idx_nx_s   = 16'd0;
      end
      I2C: begin
        if (idx_r == I2C_LAST) begin
          state_nx_s = AFTER_I2C;
          idx_nx_s   = 16'd0;
        end else begin
          idx_nx_s = idx_r + 16'd1;
        end
      end
      GPS: begin
        if (idx_r == GPS_LAST) begin
          state_nx_s = AFTER_GPS;
          idx_nx_s   = 16'd0;
        end else begin
          idx_nx_s = idx_r + 16'd1;
        end
      end
      EXT_ADDR: state_nx_s = EXT_WAIT;
      EXT_WAIT: begin
        if (idx_r == EXT_LAST) begin
          state_nx_s = AFTER_EXT;
          idx_nx_s   = 16'd0;
        end else begin
          state_nx_s = EXT_ADDR;
          idx_nx_s   = idx_r + 16'd1;
        end
      end
      PAD: begin
        if (idx_r == PAD_LAST) begin
          state_nx_s = SER_HI;
          idx_nx_s   = 16'd0;
        end else begin
          idx_nx_s = idx_r + 16'd1;
        end
      end
      SER_HI: state_nx_s = SER_LO;
`ifdef FRAME_CRC_EN
      SER_LO: state_nx_s = CRC;
      CRC:    state_nx_s = DONE;
`else
      SER_LO: state_nx_s = DONE;
`endif
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Data for the word written in the upcoming state; external words bypass this register.
  always_comb begin
    wr_data_nx_s = 16'h0000;
    case (state_nx_s)
      SYNC:   wr_data_nx_s = SYNC_WORD;
      COUNT:  wr_data_nx_s = frame_counter_r;
      I2C:    wr_data_nx_s = i2c_sh_r[15:0];
      GPS:    wr_data_nx_s = gps_sh_r[15:0];
      SER_HI: wr_data_nx_s = {serial_number[23:16], serial_number[31:24]};
      SER_LO: wr_data_nx_s = {serial_number[7:0], serial_number[15:8]};
`ifdef FRAME_CRC_EN
      CRC:    wr_data_nx_s = crc16_word(crc_r, wr_data);
`endif
      default: wr_data_nx_s = 16'h0000;
    endcase
  end

  // State, snapshots, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r         <= IDLE;
      idx_r           <= 16'd0;
      frame_d_r       <= 1'b1;
      frame_counter_r <= 16'h0000;
      i2c_sh_r        <= {(16*I2C_WORDS){1'b0}};
      gps_sh_r        <= {(16*GPS_WORDS){1'b0}};
      ext_rd_addr_r   <= {ADDR_W{1'b0}};
      wr_en_r         <= 1'b0;
      wr_addr_r       <= {ADDR_W{1'b0}};
      wr_data_r       <= 16'h0000;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      overrun_r       <= 1'b0;
`ifdef FRAME_CRC_EN
      crc_r           <= 16'hFFFF;
`endif
    end else begin
      state_r   <= state_nx_s;
      idx_r     <= idx_nx_s;
      frame_d_r <= frame;
      wr_en_r   <= (state_nx_s != IDLE) && (state_nx_s != EXT_ADDR) && (state_nx_s != DONE);
      wr_data_r <= wr_data_nx_s;
      busy_r    <= (state_nx_s != IDLE);
      done_r    <= (state_nx_s == DONE);
      overrun_r <= edge_s && (state_r != IDLE);

      if (state_r == IDLE && edge_s) begin
        wr_addr_r     <= {ADDR_W{1'b0}};
        i2c_sh_r      <= i2c_data;
        gps_sh_r      <= gps_data;
        ext_rd_addr_r <= ext_base_s;
      end else if (wr_en_r) begin
        wr_addr_r <= wr_addr_r + ADDR_ONE;
      end

      if (state_nx_s == I2C) i2c_sh_r <= i2c_sh_r >> 5'd16;
      if (state_nx_s == GPS) gps_sh_r <= gps_sh_r >> 5'd16;
      if (state_r == EXT_WAIT) ext_rd_addr_r <= ext_rd_addr_r + ADDR_ONE;
      if (state_r == COUNT) frame_counter_r <= frame_counter_r + 16'd1;

`ifdef FRAME_CRC_EN
      if (state_r == IDLE && edge_s) crc_r <= 16'hFFFF;
      else if (wr_en_r)              crc_r <= crc16_word(crc_r, wr_data);
`endif
    end
  end

  assign wr_en       = wr_en_r;
  assign wr_addr     = wr_addr_r;
  assign wr_data     = (state_r == EXT_WAIT) ? ext_data : wr_data_r;
  assign ext_rd_addr = ext_rd_addr_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_telemetry_frame_builder.sv
// Directed bench for telemetry_frame_builder: captures each frame's RAM writes and
// compares them with a hand-built frame model (CRC word checked when FRAME_CRC_EN is defined).
module tb_telemetry_frame_builder;

`ifdef FRAME_CRC_EN
  localparam int FLEN = 97;
`else
  localparam int FLEN = 96;
`endif

  logic         clock;
  logic         reset;
  logic         frame;
  logic [3:0]   frame_cnt;
  logic [159:0] i2c_data;
  logic [223:0] gps_data;
  logic [7:0]   ext_rd_addr;
  logic [15:0]  ext_data;
  logic [31:0]  serial_number;
  logic         wr_en;
  logic [7:0]   wr_addr;
  logic [15:0]  wr_data;
  logic         busy;
  logic         done;
  logic         overrun;
  logic         ext_zero;

  int n_checks, n_pass;
  int n_wr, n_done, n_ovr, seq_err, done_gap;
  logic [15:0] ram [0:255];

  telemetry_frame_builder dut (
    .clock(clock), .reset(reset), .frame(frame), .frame_cnt(frame_cnt),
    .i2c_data(i2c_data), .gps_data(gps_data), .ext_rd_addr(ext_rd_addr),
    .ext_data(ext_data), .serial_number(serial_number), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .overrun(overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // External buffer returns its own address.
  assign ext_data = ext_zero ? 16'h0000 : {8'h00, ext_rd_addr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] exp_word(input int a, input logic [15:0] cnt,
                                           input logic [1:0] sel, input logic zero);
    logic [7:0] ea;
    logic [15:0] w;
    ea = {sel, 6'd0} + 8'(a - 26);
    if (a == 0)       w = 16'hFF7F;
    else if (a == 1)  w = cnt;
    else if (a < 12)  w = zero ? 16'h0000 : 16'h0100 + 16'(a - 2);
    else if (a < 26)  w = zero ? 16'h0000 : 16'h0200 + 16'(a - 12);
    else if (a < 90)  w = zero ? 16'h0000 : {8'h00, ea};
    else if (a < 94)  w = 16'h0000;
    else if (a == 94) w = zero ? 16'h0000 : 16'h3412;
    else              w = zero ? 16'h0000 : 16'h7856;
    return w;
  endfunction

  // Bit-serial reference CRC over the 96 modelled words.
  function automatic logic [15:0] crc_ref(input logic [15:0] cnt, input logic [1:0] sel,
                                          input logic zero);
    logic [15:0] c;
    logic [15:0] w;
    logic fb;
    c = 16'hFFFF;
    for (int a = 0; a < 96; a++) begin
      w = exp_word(a, cnt, sel, zero);
      for (int b = 15; b >= 0; b--) begin
        fb = c[15] ^ w[b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic capture_frame(input int overrun_at);
    int cyc;
    int last_wr_cyc;
    int done_cyc;
    n_wr = 0; n_done = 0; n_ovr = 0; seq_err = 0;
    last_wr_cyc = -1; done_cyc = -1;
    for (int a = 0; a < 256; a++) ram[a] = 16'hDEAD;
    frame = 1'b0;
    @(negedge clock);
    frame = 1'b1;
    cyc = 0;
    while (cyc < 400 && done_cyc < 0) begin
      @(negedge clock);
      cyc++;
      if (overrun_at > 0 && cyc == 3) frame = 1'b0;
      if (overrun_at > 0 && cyc == overrun_at) frame = 1'b1;
      if (wr_en) begin
        if (wr_addr != n_wr[7:0]) seq_err++;
        ram[wr_addr] = wr_data;
        n_wr++;
        last_wr_cyc = cyc;
      end
      if (done) begin n_done++; done_cyc = cyc; end
      if (overrun) n_ovr++;
    end
    repeat (4) begin
      @(negedge clock);
      if (wr_en) n_wr++;
      if (done) n_done++;
      if (overrun) n_ovr++;
    end
    check("done_seen", done_cyc >= 0, 1);
    done_gap = done_cyc - last_wr_cyc;
    frame = 1'b0;
  endtask

  task automatic verify_frame(input string name, input logic [15:0] cnt,
                              input logic [1:0] sel, input logic zero);
    int bad;
    bad = 0;
    for (int a = 0; a < 96; a++) if (ram[a] !== exp_word(a, cnt, sel, zero)) bad++;
    check({name, "_bad_words"}, bad, 0);
    check({name, "_writes"}, n_wr, FLEN);
    check({name, "_addr_seq"}, seq_err, 0);
    check({name, "_done_pulses"}, n_done, 1);
    check({name, "_done_gap"}, done_gap, 1);
    check({name, "_idle_busy"}, busy, 0);
`ifdef FRAME_CRC_EN
    check({name, "_crc"}, ram[96], crc_ref(cnt, sel, zero));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hit;
    int cyc;
    int stray;
    n_checks = 0; n_pass = 0;
    reset = 1'b1; frame = 1'b0; frame_cnt = 4'b0100; ext_zero = 1'b0;
    serial_number = 32'h12345678;
    for (int k = 0; k < 10; k++) i2c_data[16*k +: 16] = 16'h0100 + 16'(k);
    for (int k = 0; k < 14; k++) gps_data[16*k +: 16] = 16'h0200 + 16'(k);
    repeat (3) @(negedge clock);
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_ext_addr", ext_rd_addr, 0);
    reset = 1'b0;

    // Frame A: counter 0, subframe 1
    capture_frame(0);
    verify_frame("frmA", 16'h0000, 2'd1, 1'b0);
    check("frmA_a0", ram[0], 16'hFF7F);
    check("frmA_a1", ram[1], 16'h0000);
    check("frmA_a2", ram[2], 16'h0100);
    check("frmA_a12", ram[12], 16'h0200);
    check("frmA_a26", ram[26], 16'h0040);
    check("frmA_a89", ram[89], 16'h007F);
    check("frmA_pad", ram[90] | ram[91] | ram[92] | ram[93], 16'h0000);
    check("frmA_a94", ram[94], 16'h3412);
    check("frmA_a95", ram[95], 16'h7856);
    check("frmA_overrun", n_ovr, 0);

    // Frame B: extra edge at cycle 10
    capture_frame(10);
    verify_frame("frmB", 16'h0001, 2'd1, 1'b0);
    check("frmB_overrun", n_ovr, 1);

    // Frame C: subframe 3 reaches the top of the address space
    frame_cnt = 4'b1110;
    capture_frame(0);
    verify_frame("frmC", 16'h0002, 2'd3, 1'b0);
    check("frmC_a1", ram[1], 16'h0002);
    check("frmC_a26", ram[26], 16'h00C0);
    check("frmC_a89", ram[89], 16'h00FF);

    // Counter wrap
    force dut.frame_counter_r = 16'hFFFF;
    @(negedge clock);
    release dut.frame_counter_r;
    frame_cnt = 4'b0000;
    capture_frame(0);
    verify_frame("frmD", 16'hFFFF, 2'd0, 1'b0);
    check("frmD_a1", ram[1], 16'hFFFF);
    frame_cnt = 4'b1000;
    capture_frame(0);
    verify_frame("frmE", 16'h0000, 2'd2, 1'b0);
    check("frmE_a1", ram[1], 16'h0000);

    // Reset at write 40 with frame held high
    frame_cnt = 4'b0100;
    @(negedge clock);
    frame = 1'b1;
    hit = 0; cyc = 0;
    while (cyc < 300 && hit == 0) begin
      @(negedge clock);
      cyc++;
      if (wr_en && wr_addr == 8'd40) hit = 1;
    end
    check("rst40_reached", hit, 1);
    reset = 1'b1;
    @(negedge clock);
    check("rst40_wr_en", wr_en, 0);
    check("rst40_busy", busy, 0);
    check("rst40_wr_addr", wr_addr, 0);
    check("rst40_wr_data", wr_data, 0);
    check("rst40_ext_addr", ext_rd_addr, 0);
    check("rst40_done_ovr", {done, overrun}, 0);
    reset = 1'b0;
    stray = 0;
    repeat (20) begin
      @(negedge clock);
      if (wr_en || busy) stray++;
    end
    check("rst40_no_restart", stray, 0);
    capture_frame(0);
    verify_frame("frmG", 16'h0000, 2'd1, 1'b0);

`ifdef FRAME_CRC_EN
    ext_zero = 1'b1;
    serial_number = 32'h0000_0000;
    i2c_data = '0;
    gps_data = '0;
    capture_frame(0);
    verify_frame("frmZ", 16'h0001, 2'd1, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
